// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pkg
//  Description : Shared definitions for the instruction-fetch prefetch stage:
//                NOP word, fetch FSM encoding and prefetch buffer entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0) presented when nothing is valid
    localparam logic [31:0] c_NOP     = 32'h0000_0013;

    // A buffer entry is tagged with the word address (byte address [31:2])
    localparam int          c_TAG_W   = 30;
    localparam int          c_DATA_W  = 32;
    localparam int          c_ENTRY_W = c_TAG_W + c_DATA_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // no request outstanding
        S_BUSY  = 2'd1,   // live request outstanding, data will be kept
        S_DRAIN = 2'd2    // stale request outstanding, data will be dropped
    } fetch_state_t;

    typedef struct packed {
        logic [c_TAG_W-1:0]  tag;
        logic [c_DATA_W-1:0] data;
    } buf_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_buffer
//  Description : Tagged circular FIFO holding prefetched instruction words.
//                Flush has priority over push/pop; simultaneous push and pop
//                leave the count unchanged. DEPTH must be a power of two.
//  Ports       : i_clk        clock
//                i_rst_n      asynchronous active-low reset
//                i_flush      empty the buffer at the next edge
//                i_push       write i_push_entry at the tail
//                i_push_entry {word address tag, instruction data}
//                i_pop        drop the head entry
//                o_head       current head entry (meaningful when count > 0)
//                o_count      number of valid entries, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_buffer
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_flush,
    input  logic                           i_push,
    input  buf_entry_t                     i_push_entry,
    input  logic                           i_pop,
    output buf_entry_t                     o_head,
    output logic [$clog2(DEPTH + 1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    buf_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed below r_count
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_prefetch
//  Description : Instruction-fetch stage with a small tagged prefetch buffer
//                filled over a classic Wishbone master (one outstanding
//                request). Any PC discontinuity flushes the buffer and
//                redirects fetching; a request already on the bus is drained.
//  Ports       : i_CLK / i_RSTn          clock / async active-low reset
//                i_PC, i_EN              core address and decode enable
//                o_INSTRUCTION(_VALID)   word for i_PC, NOP when not valid
//                o_WB_ADDR/STB/CYC       registered Wishbone request
//                i_WB_DATA, i_WB_ACK     Wishbone response
//  Options     : IFETCH_BYPASS_EN - forward an ACKed word straight to the
//                core when the buffer is empty and it matches i_PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_prefetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic [31:0] i_PC,
    input  logic        i_EN,
    output logic [31:0] o_INSTRUCTION,
    output logic        o_INSTRUCTION_VALID,
    output logic [31:0] o_WB_ADDR,
    input  logic [31:0] i_WB_DATA,
    output logic        o_WB_STB,
    output logic        o_WB_CYC,
    input  logic        i_WB_ACK
);

    localparam int               CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

    fetch_state_t     r_state;
    logic [31:0]      r_fetch_addr;
    logic [31:0]      r_wb_addr;
    logic             r_wb_stb;

    buf_entry_t       w_head;
    buf_entry_t       w_push_entry;
    logic [CNT_W-1:0] w_count;
    logic [31:0]      w_pc_word;
    logic [31:0]      w_expected;
    logic             w_nonempty;
    logic             w_hit;
    logic             w_redirect;
    logic             w_pop;
    logic             w_push;
    logic             w_ack_live;
    logic             w_bypass;
    logic             w_slot_free;

    // Byte offset of the PC is ignored; the masking keeps every bit referenced
    assign w_pc_word  = {i_PC[31:2], i_PC[1:0] & 2'b00};
    assign w_nonempty = (w_count != '0);

    // Address the core is expected to ask for next
    always_comb begin
        w_expected = r_fetch_addr;
        if (w_nonempty) begin
            w_expected = {w_head.tag, 2'b00};
        end else if (r_state == S_BUSY) begin
            w_expected = r_wb_addr;
        end
    end

    assign w_redirect  = (w_pc_word != w_expected);
    assign w_hit       = w_nonempty && (w_head.tag == w_pc_word[31:2]);
    assign w_pop       = w_hit && i_EN;
    assign w_ack_live  = (r_state == S_BUSY) && i_WB_ACK && !w_redirect;
    assign w_slot_free = (w_count != c_FULL) || w_pop;

`ifdef IFETCH_BYPASS_EN
    // A bypass match implies no redirect, since the expected address is then
    // the in-flight address
    assign w_bypass = !w_nonempty && (r_state == S_BUSY) && i_WB_ACK &&
                      (r_wb_addr[31:2] == w_pc_word[31:2]);
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that the core consumes this cycle is not buffered
    assign w_push            = w_ack_live && !(w_bypass && i_EN);
    assign w_push_entry.tag  = r_wb_addr[31:2];
    assign w_push_entry.data = i_WB_DATA;

    ifetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .i_clk        (i_CLK),
        .i_rst_n      (i_RSTn),
        .i_flush      (w_redirect),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    always_comb begin
        o_INSTRUCTION       = c_NOP;
        o_INSTRUCTION_VALID = 1'b0;
        if (w_hit) begin
            o_INSTRUCTION       = w_head.data;
            o_INSTRUCTION_VALID = 1'b1;
        end else if (w_bypass) begin
            o_INSTRUCTION       = i_WB_DATA;
            o_INSTRUCTION_VALID = 1'b1;
        end
    end

    // Fetch FSM with registered Wishbone outputs
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_state      <= S_IDLE;
            r_fetch_addr <= RESET_PC;
            r_wb_addr    <= RESET_PC;
            r_wb_stb     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_redirect) begin
                        // Go straight to the new target; the flush frees space
                        r_wb_addr    <= w_pc_word;
                        r_fetch_addr <= w_pc_word + 32'd4;
                        r_wb_stb     <= 1'b1;
                        r_state      <= S_BUSY;
                    end else if (w_slot_free) begin
                        r_wb_addr    <= r_fetch_addr;
                        r_fetch_addr <= r_fetch_addr + 32'd4;
                        r_wb_stb     <= 1'b1;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_redirect) begin
                        r_fetch_addr <= w_pc_word;
                    end
                    if (i_WB_ACK) begin
                        r_wb_stb <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_redirect) begin
                        r_state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Classic Wishbone cannot abort: wait out the stale ACK
                    if (w_redirect) begin
                        r_fetch_addr <= w_pc_word;
                    end
                    if (i_WB_ACK) begin
                        r_wb_stb <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_wb_stb <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_WB_ADDR = r_wb_addr;
    assign o_WB_STB  = r_wb_stb;
    assign o_WB_CYC  = r_wb_stb;

endmodule
`default_nettype wire
